// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: fetches stored frames from DDR over AXI, one line per request, streaming 256-bit beats downstream.
module ddr_frame_reader #(
   parameter logic [27:0] BASE_ADDR = 28'h0000000,
   parameter int          H_ACT     = 1280,
   parameter int          V_ACT     = 720,
   parameter int          PIX_BITS  = 16,
   parameter int          BURST_LEN = 16,
   parameter logic [3:0]  AXI_ID    = 4'd1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         frame_start,
   input  logic         line_req,
   input  logic [7:0]   out_free,
   output logic [27:0]  axi_araddr,
   output logic         axi_aruser_ap,
   output logic [3:0]   axi_aruser_id,
   output logic [3:0]   axi_arlen,
   output logic         axi_arvalid,
   input  logic         axi_arready,
   input  logic [255:0] axi_rdata,
   input  logic [3:0]   axi_rid,
   input  logic         axi_rlast,
   input  logic         axi_rvalid,
   output logic [255:0] out_data,
   output logic         out_valid,
   output logic         out_sol,
   output logic         out_eof,
   output logic         frame_done,
   output logic         busy,
   output logic         err
);
   localparam int BEATS  = H_ACT * PIX_BITS / 256;
   localparam int BURSTS = BEATS / BURST_LEN;
   localparam int LW     = $clog2(V_ACT + 1);
   localparam int BW     = $clog2(BURSTS + 1);
   localparam logic [27:0] STRIDE = 28'(BURST_LEN * 8);

   if (H_ACT * PIX_BITS % 256 != 0 || BURST_LEN < 1 || BURST_LEN > 16 || BEATS % BURST_LEN != 0 || BURSTS < 1) begin : g_geometry_check
      $error("ddr_frame_reader: a line must split into whole bursts of 256-bit beats");
   end

   typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, NEXT} state_t;
   state_t        state;
   logic [LW-1:0] line;
   logic [BW-1:0] burst;
   logic [3:0]    beat;
   logic [1:0]    pend, pend_n;
   logic          restart_pend, restart, eol, clr, dec, last_burst, last_line, beat_last;

   assign axi_aruser_ap = 1'b1;
   assign axi_aruser_id = AXI_ID;
   assign axi_arlen     = 4'(BURST_LEN - 1);
   assign busy          = state != IDLE;

   // restart wins over the line advance; a frame wrap clears pending like a restart
   always_comb begin
      last_burst = burst == BW'(BURSTS - 1);
      last_line  = line == LW'(V_ACT - 1);
      beat_last  = beat == 4'(BURST_LEN - 1);
      restart    = restart_pend | frame_start;
      eol        = state == NEXT && !restart && last_burst;
      clr        = (frame_start && (state == IDLE || state == CHECK)) || (state == NEXT && restart) || (eol && last_line);
      dec        = eol && !last_line && pend != 2'd0;
      pend_n     = clr ? {1'b0, line_req} : (line_req && !dec) ? (pend == 2'd3 ? pend : pend + 2'd1) : (!line_req && dec) ? pend - 2'd1 : pend;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         line         <= '0;
         burst        <= '0;
         beat         <= '0;
         pend         <= '0;
         restart_pend <= 1'b0;
         axi_araddr   <= BASE_ADDR;
         axi_arvalid  <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_sol      <= 1'b0;
         out_eof      <= 1'b0;
         frame_done   <= 1'b0;
         err          <= 1'b0;
      end else begin
         out_data   <= axi_rdata;
         out_valid  <= axi_rvalid;
         out_sol    <= axi_rvalid && state == DATA && burst == '0 && beat == '0;
         out_eof    <= axi_rvalid && axi_rlast && state == DATA && last_burst && last_line;
         frame_done <= out_eof;
         pend       <= pend_n;
         if (axi_rvalid && (axi_rid != AXI_ID || state inside {IDLE, CHECK, ADDR} || (state == DATA && axi_rlast != beat_last)))
            err <= 1'b1;
         if (clr) begin
            line       <= '0;
            burst      <= '0;
            axi_araddr <= BASE_ADDR;
         end
         case (state)
            IDLE: if (!frame_start && pend != 2'd0) state <= CHECK;
            CHECK: begin
               if (frame_start) state <= IDLE;
               else if (out_free >= 8'(BURST_LEN)) begin
                  axi_arvalid <= 1'b1;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               restart_pend <= restart;
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  beat        <= '0;
                  state       <= DATA;
               end
            end
            DATA: begin
               restart_pend <= restart;
               if (axi_rvalid) begin
                  beat <= beat_last ? '0 : beat + 4'd1;
                  if (axi_rlast) state <= NEXT;
               end
            end
            NEXT: begin
               restart_pend <= 1'b0;
               if (!restart && !last_burst) begin
                  burst      <= burst + BW'(1);
                  axi_araddr <= axi_araddr + STRIDE;
                  state      <= CHECK;
               end else begin
                  state <= IDLE;
                  if (eol && !last_line) begin
                     burst      <= '0;
                     line       <= line + LW'(1);
                     axi_araddr <= axi_araddr + STRIDE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
